// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable simple dual-port RAM.
package ram_pkg;

    localparam int LANE_W = 8;

    typedef logic [0:0] state_t;

    localparam state_t CLEAR = 1'b0;
    localparam state_t READY = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/ram_sdp_be_if.sv
// Write/read/clear bus of the byte-enable simple dual-port RAM.
interface ram_sdp_be_if #(
    parameter int WIDTH  = 8,
    parameter int A_SIZE = 8
);
    import ram_pkg::*;

    localparam int NB = WIDTH / LANE_W;

    logic              clr_req;
    logic              busy;
    logic              wr_en;
    logic [A_SIZE-1:0] wr_addr;
    logic [NB-1:0]     wr_be;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [A_SIZE-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              rd_oor;

    modport master (
        output clr_req,
        output wr_en,
        output wr_addr,
        output wr_be,
        output wr_data,
        output rd_en,
        output rd_addr,
        input  busy,
        input  rd_data,
        input  rd_valid,
        input  rd_oor
    );

    modport slave (
        input  clr_req,
        input  wr_en,
        input  wr_addr,
        input  wr_be,
        input  wr_data,
        input  rd_en,
        input  rd_addr,
        output busy,
        output rd_data,
        output rd_valid,
        output rd_oor
    );

endinterface

// File: rtl/ram_clear_fsm.sv
// Clear engine: walks the array writing zeros after reset or on request.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int A_SIZE = 8,
    parameter int DEPTH  = 2 ** A_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [A_SIZE-1:0] clr_addr
);

    localparam logic [A_SIZE-1:0] LAST = A_SIZE'(DEPTH - 1);

    state_t            state;
    logic [A_SIZE-1:0] addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            addr  <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    if (addr == LAST) begin
                        state <= READY;
                        addr  <= '0;
                    end else begin
                        addr <= addr + A_SIZE'(1);
                    end
                end
                READY: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        addr  <= '0;
                    end
                end
            endcase
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = addr;

endmodule

// File: rtl/ram_sdp_be.sv
// Byte-enable simple dual-port RAM with built-in clear engine.
// Define RAM_OUT_REG_EN to add an output register stage (read latency 2).
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int A_SIZE = 8,
    parameter int DEPTH  = 2 ** A_SIZE
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_sdp_be_if.slave  bus
);

    localparam int              NB      = WIDTH / LANE_W;
    localparam logic [A_SIZE:0] DEPTH_W = (A_SIZE + 1)'(DEPTH);

    if ((WIDTH % LANE_W) != 0 || DEPTH < 1 || clog2(DEPTH) > A_SIZE) begin : g_bad_cfg
        $error("ram_sdp_be: illegal WIDTH/DEPTH configuration");
    end

    logic              busy;
    logic              clr_we;
    logic [A_SIZE-1:0] clr_addr;

    ram_clear_fsm #(
        .A_SIZE (A_SIZE),
        .DEPTH  (DEPTH)
    ) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (bus.clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.busy = busy;

    // A clear request in READY wins over any same-cycle user access.
    logic user_ok;
    logic wr_in;
    logic rd_in;
    logic wr_ok;
    logic rd_ok;

    assign user_ok = !busy && !bus.clr_req;
    assign wr_in   = {1'b0, bus.wr_addr} < DEPTH_W;
    assign rd_in   = {1'b0, bus.rd_addr} < DEPTH_W;
    assign wr_ok   = user_ok && bus.wr_en && wr_in;
    assign rd_ok   = user_ok && bus.rd_en;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wr_be[b]) begin
                    mem[bus.wr_addr][b*LANE_W +: LANE_W] <= bus.wr_data[b*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Write-first per lane when both ports hit the same word.
    logic [WIDTH-1:0] rd_word;

    always_comb begin
        rd_word = rd_in ? mem[bus.rd_addr] : '0;
        if (wr_ok && bus.wr_addr == bus.rd_addr) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wr_be[b]) begin
                    rd_word[b*LANE_W +: LANE_W] = bus.wr_data[b*LANE_W +: LANE_W];
                end
            end
        end
    end

    logic             s1_valid;
    logic             s1_oor;
    logic [WIDTH-1:0] s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_oor   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_ok;
            s1_oor   <= rd_ok && !rd_in;
            if (rd_ok) begin
                s1_data <= rd_word;
            end
        end
    end

`ifdef RAM_OUT_REG_EN
    logic             s2_valid;
    logic             s2_oor;
    logic [WIDTH-1:0] s2_data;

    // Drains regardless of busy so a read issued just before a clear completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_oor   <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_oor   <= s1_oor;
            if (s1_valid) begin
                s2_data <= s1_data;
            end
        end
    end

    assign bus.rd_valid = s2_valid;
    assign bus.rd_oor   = s2_oor;
    assign bus.rd_data  = s2_data;
`else
    assign bus.rd_valid = s1_valid;
    assign bus.rd_oor   = s1_oor;
    assign bus.rd_data  = s1_data;
`endif

endmodule

// File: tb/tb_ram_sdp_be.sv
// Self-checking bench for ram_sdp_be against a word-array reference model.
module tb_ram_sdp_be;

    localparam int W  = 32;
    localparam int AS = 8;
    localparam int D  = 200;
    localparam int DF = 256;
`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic         v;
        logic         oor;
        logic [W-1:0] d;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ram_sdp_be_if #(.WIDTH(W), .A_SIZE(AS)) bus_a ();
    ram_sdp_be_if #(.WIDTH(8), .A_SIZE(AS)) bus_f ();

    ram_sdp_be #(.WIDTH(W), .A_SIZE(AS), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    ram_sdp_be #(.WIDTH(8), .A_SIZE(AS), .DEPTH(DF)) dut_f (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f.slave)
    );

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [W-1:0] ref_mem [DF];
    int           rem;
    rec_t         exp_q [$];
    logic [W-1:0] last_d;

    // After reset the array is unreachable until the clear finishes, then all zero.
    function automatic void model_reset();
        rem    = D;
        last_d = '0;
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
        for (int i = 0; i < DF; i++) ref_mem[i] = '0;
    endfunction

    task automatic step(input logic clr, input logic we, input logic [7:0] wa,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic re, input logic [7:0] ra);
        rec_t r;
        bus_a.clr_req = clr;
        bus_a.wr_en   = we;
        bus_a.wr_addr = wa;
        bus_a.wr_be   = be;
        bus_a.wr_data = wd;
        bus_a.rd_en   = re;
        bus_a.rd_addr = ra;
        n_chk++;
        if (bus_a.busy !== (rem > 0)) begin
            n_fail++;
            $display("FAIL busy: got %b want %b", bus_a.busy, rem > 0);
        end
        r = '0;
        if (rem > 0) begin
            rem--;
        end else if (clr) begin
            rem = D;
            for (int i = 0; i < DF; i++) ref_mem[i] = '0;
        end else begin
            if (we && wa < D)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[wa][b*8 +: 8] = wd[b*8 +: 8];
            if (re) begin
                r.v   = 1'b1;
                r.oor = (ra >= D);
                r.d   = (ra < D) ? ref_mem[ra] : '0;
            end
        end
        exp_q.push_back(r);
        @(posedge clk);
        @(negedge clk);
        r = exp_q.pop_front();
        if (r.v) last_d = r.d;
        n_chk++;
        if (bus_a.rd_valid !== r.v) begin
            n_fail++;
            $display("FAIL rd_valid: got %b want %b", bus_a.rd_valid, r.v);
        end
        n_chk++;
        if (bus_a.rd_data !== last_d) begin
            n_fail++;
            $display("FAIL rd_data: got %h want %h", bus_a.rd_data, last_d);
        end
        if (r.v) begin
            n_chk++;
            if (bus_a.rd_oor !== r.oor) begin
                n_fail++;
                $display("FAIL rd_oor: got %b want %b", bus_a.rd_oor, r.oor);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h0, 4'h0, 32'h0, 0, 8'h0);
    endtask

    task automatic expect_word(input string name, input logic [W-1:0] want);
        n_chk++;
        if (bus_a.rd_data !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, bus_a.rd_data, want);
        end
    endtask

    task automatic test_reset();
        int ca;
        int cf;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk += 5;
        if (bus_a.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", bus_a.busy); end
        if (bus_f.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_f: got %b want 1", bus_f.busy); end
        if (bus_a.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus_a.rd_valid); end
        if (bus_a.rd_oor !== 1'b0) begin n_fail++; $display("FAIL rst_oor: got %b want 0", bus_a.rd_oor); end
        if (bus_a.rd_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", bus_a.rd_data); end
        rst_n = 1'b1;
        model_reset();
        ca = 0;
        cf = 0;
        for (int c = 0; c < 600 && (bus_a.busy || bus_f.busy); c++) begin
            if (bus_a.busy) ca++;
            if (bus_f.busy) cf++;
            @(posedge clk);
            @(negedge clk);
        end
        rem = 0;
        n_chk += 2;
        if (ca != D) begin n_fail++; $display("FAIL busy_len: got %0d want %0d", ca, D); end
        if (cf != DF) begin n_fail++; $display("FAIL busy_len_f: got %0d want %0d", cf, DF); end
    endtask

    task automatic test_read_all_f();
        for (int a = 0; a < DF; a++) begin
            bus_f.rd_en   = 1'b1;
            bus_f.rd_addr = 8'(a);
            @(posedge clk);
            @(negedge clk);
            bus_f.rd_en = 1'b0;
            for (int k = 1; k < LAT; k++) begin
                @(posedge clk);
                @(negedge clk);
            end
            n_chk++;
            if (bus_f.rd_valid !== 1'b1 || bus_f.rd_data !== 8'h00 || bus_f.rd_oor !== 1'b0) begin
                n_fail++;
                $display("FAIL read_all_f @%0d: got v=%b d=%h o=%b want v=1 d=00 o=0",
                         a, bus_f.rd_valid, bus_f.rd_data, bus_f.rd_oor);
            end
        end
    endtask

    task automatic test_byte_lanes();
        step(0, 1, 8'h10, 4'hF, 32'hAABBCCDD, 0, 8'h0);
        step(0, 1, 8'h10, 4'h5, 32'h11223344, 0, 8'h0);
        step(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'h10);
        idle(LAT - 1);
        expect_word("byte_merge", 32'hAA22CC44);
        step(0, 1, 8'h10, 4'h0, 32'hFFFFFFFF, 0, 8'h0);
        step(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'h10);
        idle(LAT - 1);
        expect_word("be_zero", 32'hAA22CC44);
    endtask

    task automatic test_bypass();
        step(0, 1, 8'h05, 4'hF, 32'h00001234, 0, 8'h0);
        step(0, 1, 8'h05, 4'h1, 32'h000000FF, 1, 8'h05);
        idle(LAT - 1);
        expect_word("bypass", 32'h000012FF);
        step(0, 1, 8'h06, 4'hF, 32'hCAFEF00D, 1, 8'h05);
        idle(LAT - 1);
        expect_word("diff_addr", 32'h000012FF);
    endtask

    task automatic test_oor();
        step(0, 1, 8'd250, 4'hF, 32'hFFFFFFFF, 0, 8'h0);
        step(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'd250);
        idle(LAT - 1);
        n_chk++;
        if (bus_a.rd_valid !== 1'b1 || bus_a.rd_oor !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_flags: got v=%b o=%b want v=1 o=1", bus_a.rd_valid, bus_a.rd_oor);
        end
        expect_word("oor_data", '0);
        for (int a = 0; a < DF; a++) step(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'(a));
        idle(LAT);
    endtask

    task automatic test_random();
        logic [7:0] wa;
        logic [7:0] ra;
        for (int i = 0; i < 800; i++) begin
            wa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            ra = ($urandom_range(0, 2) == 0) ? wa : 8'($urandom_range(0, 15));
            step($urandom_range(0, 299) == 0, 1'($urandom), wa, 4'($urandom),
                 $urandom, 1'($urandom), ra);
        end
        idle(LAT);
    endtask

    task automatic test_clear_mid();
        int cnt;
        for (int i = 0; i < 20; i++)
            step(0, 1, 8'($urandom_range(0, 15)), 4'hF, $urandom | 32'h1, 1, 8'(i % 16));
        step(0, 1, 8'h02, 4'hF, 32'h5A5A5A5A, 0, 8'h0);
        step(1, 1, 8'h02, 4'hF, 32'h12345678, 1, 8'h02);
        cnt = 0;
        while (bus_a.busy && cnt < 1000) begin
            idle(1);
            cnt++;
        end
        n_chk++;
        if (cnt != D) begin n_fail++; $display("FAIL clear_len: got %0d want %0d", cnt, D); end
        for (int a = 0; a < DF; a++) step(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'(a));
        idle(LAT);
        step(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'h02);
        idle(LAT - 1);
        expect_word("clear_zero", '0);
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        step(0, 1, 8'h03, 4'hF, 32'hDEADBEEF, 1, 8'h03);
        step(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'h03);
        step(1, 0, 8'h0, 4'h0, 32'h0, 0, 8'h0);
        idle(37);
        expect_word("hold_in_clear", 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        n_chk += 4;
        if (bus_a.busy !== 1'b1) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 1", bus_a.busy); end
        if (bus_a.rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", bus_a.rd_valid); end
        if (bus_a.rd_oor !== 1'b0) begin n_fail++; $display("FAIL mid_rst_oor: got %b want 0", bus_a.rd_oor); end
        if (bus_a.rd_data !== '0) begin n_fail++; $display("FAIL mid_rst_data: got %h want 0", bus_a.rd_data); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cnt = 0;
        while (bus_a.busy && cnt < 1000) begin
            idle(1);
            cnt++;
        end
        n_chk++;
        if (cnt != D) begin n_fail++; $display("FAIL restart_len: got %0d want %0d", cnt, D); end
        for (int a = 0; a < 8; a++) step(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'(a));
        idle(LAT);
    endtask

    initial begin
        bus_a.clr_req = 1'b0;
        bus_a.wr_en   = 1'b0;
        bus_a.wr_addr = '0;
        bus_a.wr_be   = '0;
        bus_a.wr_data = '0;
        bus_a.rd_en   = 1'b0;
        bus_a.rd_addr = '0;
        bus_f.clr_req = 1'b0;
        bus_f.wr_en   = 1'b0;
        bus_f.wr_addr = '0;
        bus_f.wr_be   = '0;
        bus_f.wr_data = '0;
        bus_f.rd_en   = 1'b0;
        bus_f.rd_addr = '0;
        test_reset();
        test_read_all_f();
        test_byte_lanes();
        test_bypass();
        test_oor();
        test_random();
        test_clear_mid();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
